// File: rtl/frame_buffer_arbiter_pkg.sv
// rtl/frame_buffer_arbiter_pkg.sv - shared constants and FSM encoding for the frame buffer arbiter
package frame_buffer_arbiter_pkg;

   localparam int FBA_DATA_W       = 16;
   localparam int FBA_ADDR_W       = 17;
   localparam int FBA_FRAME_PIXELS = 76800;
   localparam int FBA_FIFO_DEPTH   = 4;

   typedef enum logic {
      fba_wait_sync_p = 1'b0,
      fba_run_p       = 1'b1
   } fba_state_e;

endpackage

// File: rtl/frame_buffer_arbiter_pixel_fifo.sv
// rtl/frame_buffer_arbiter_pixel_fifo.sv - pixel_fifo: registered camera write FIFO with push/pop/flush
// Head is read straight from storage; a pushed word is visible one cycle later.
module pixel_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int             PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = push_i ? PTR_ONE : '0;
         if (push_i) begin
            mem_d[0] = push_data_i;
         end
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - single-port pixel RAM arbiter: VGA reads win, camera writes drain from a FIFO
// Owns the write/read address counters, frame wrap, overflow and frame-done signalling.
module frame_buffer_arbiter
   import frame_buffer_arbiter_pkg::*;
#(
   parameter int DATA_W       = FBA_DATA_W,
   parameter int ADDR_W       = FBA_ADDR_W,
   parameter int FRAME_PIXELS = FBA_FRAME_PIXELS,
   parameter int FIFO_DEPTH   = FBA_FIFO_DEPTH
) (
   input  logic              Clk_i,
   input  logic              Reset_i,
   input  logic              Wr_Frame_Start_i,
   input  logic              Wr_Valid_i,
   input  logic [DATA_W-1:0] Wr_Data_i,
   input  logic              Rd_Frame_Start_i,
   input  logic              Rd_En_i,
   output logic [DATA_W-1:0] Pixel_o,
   output logic              Pixel_Valid_o,
   output logic              Mem_En_o,
   output logic              Mem_Wr_En_o,
   output logic [ADDR_W-1:0] Mem_Addr_o,
   output logic [DATA_W-1:0] Mem_Wr_Data_o,
   input  logic [DATA_W-1:0] Mem_Rd_Data_i,
   output logic              Frame_Done_o,
   output logic              Overflow_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   fba_state_e        state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_issue_q, rd_issue_d;
   logic [DATA_W-1:0] pixel_q, pixel_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;

   logic              fifo_push, fifo_pop, fifo_flush;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic [ADDR_W-1:0] rd_use_addr;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_ONE;
   endfunction

   pixel_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_pixel_fifo (
      .clk_i       (Clk_i),
      .reset_i     (Reset_i),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (Wr_Data_i),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      rd_addr_d     = rd_addr_q;
      rd_issue_d    = 1'b0;
      pixel_valid_d = rd_issue_q;
      pixel_d       = rd_issue_q ? Mem_Rd_Data_i : '0;
      frame_done_d  = 1'b0;
      overflow_d    = overflow_q;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      fifo_flush    = 1'b0;
      rd_use_addr   = Rd_Frame_Start_i ? '0 : rd_addr_q;
      Mem_En_o      = 1'b0;
      Mem_Wr_En_o   = 1'b0;
      Mem_Addr_o    = wr_addr_q;
      Mem_Wr_Data_o = '0;

      if (Reset_i) begin
         Mem_Addr_o = '0;
      end else begin
         // The VGA side is real-time, so a read always takes the port.
         if (Rd_En_i) begin
            Mem_En_o   = 1'b1;
            Mem_Addr_o = rd_use_addr;
            rd_addr_d  = addr_inc(rd_use_addr);
            rd_issue_d = 1'b1;
         end else if (Rd_Frame_Start_i) begin
            rd_addr_d = '0;
         end

         if (!Rd_En_i && !fifo_empty && !Wr_Frame_Start_i) begin
            fifo_pop      = 1'b1;
            Mem_En_o      = 1'b1;
            Mem_Wr_En_o   = 1'b1;
            Mem_Addr_o    = wr_addr_q;
            Mem_Wr_Data_o = fifo_head;
            wr_addr_d     = addr_inc(wr_addr_q);
            frame_done_d  = (wr_addr_q == LAST_ADDR);
         end

         case (state_q)
            fba_wait_sync_p: begin
               if (Wr_Frame_Start_i) begin
                  state_d   = fba_run_p;
                  wr_addr_d = '0;
               end
            end
            default: begin
               // A frame start discards stale pixels; a same-cycle pixel becomes pixel 0.
               if (Wr_Frame_Start_i) begin
                  fifo_flush = 1'b1;
                  wr_addr_d  = '0;
               end
               if (Wr_Valid_i) begin
                  if (Wr_Frame_Start_i || !fifo_full || fifo_pop) begin
                     fifo_push = 1'b1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q       <= fba_wait_sync_p;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         rd_issue_q    <= 1'b0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         rd_issue_q    <= rd_issue_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         frame_done_q  <= frame_done_d;
         overflow_q    <= overflow_d;
      end
   end

   assign Pixel_o       = pixel_q;
   assign Pixel_Valid_o = pixel_valid_q;
   assign Frame_Done_o  = frame_done_q;
   assign Overflow_o    = overflow_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - table, directed and randomized checks of frame_buffer_arbiter against a queue model
module tb_frame_buffer_arbiter;

   localparam int FP    = 48;
   localparam int DEPTH = 4;
   localparam int AW    = 17;
   localparam int DW    = 16;

   logic          clk;
   logic          Reset_i, Wr_Frame_Start_i, Wr_Valid_i, Rd_Frame_Start_i, Rd_En_i;
   logic [DW-1:0] Wr_Data_i, Pixel_o, Mem_Wr_Data_o, Mem_Rd_Data_i;
   logic          Pixel_Valid_o, Mem_En_o, Mem_Wr_En_o, Frame_Done_o, Overflow_o;
   logic [AW-1:0] Mem_Addr_o;

   frame_buffer_arbiter #(
      .DATA_W (DW), .ADDR_W (AW), .FRAME_PIXELS (FP), .FIFO_DEPTH (DEPTH)
   ) dut (
      .Clk_i            (clk),
      .Reset_i          (Reset_i),
      .Wr_Frame_Start_i (Wr_Frame_Start_i),
      .Wr_Valid_i       (Wr_Valid_i),
      .Wr_Data_i        (Wr_Data_i),
      .Rd_Frame_Start_i (Rd_Frame_Start_i),
      .Rd_En_i          (Rd_En_i),
      .Pixel_o          (Pixel_o),
      .Pixel_Valid_o    (Pixel_Valid_o),
      .Mem_En_o         (Mem_En_o),
      .Mem_Wr_En_o      (Mem_Wr_En_o),
      .Mem_Addr_o       (Mem_Addr_o),
      .Mem_Wr_Data_o    (Mem_Wr_Data_o),
      .Mem_Rd_Data_i    (Mem_Rd_Data_i),
      .Frame_Done_o     (Frame_Done_o),
      .Overflow_o       (Overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input int a);
      return 16'(a * 40503 + 4660);
   endfunction

   // RAM stand-in: reads return an address-derived pattern, idle cycles return junk.
   always @(posedge clk)
      Mem_Rd_Data_i <= (Mem_En_o && !Mem_Wr_En_o) ? pat(int'(Mem_Addr_o)) : 16'($urandom);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending pixels as a queue, addresses as plain integers.
   bit          m_run, m_ovf, m_fd, m_pv, m_iss;
   int          m_wa, m_ra, m_iss_addr;
   logic [15:0] m_px;
   logic [15:0] m_q[$];

   logic          s_en, s_we, s_pv, s_fd, s_ovf;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wd, s_px;
   int            lw_addr, fd_count;
   logic [15:0]   lw_data;

   task automatic model_reset();
      m_run = 0; m_wa = 0; m_ra = 0; m_q.delete(); m_ovf = 0; m_fd = 0;
      m_pv = 0; m_px = 16'h0; m_iss = 0; m_iss_addr = 0;
   endtask

   task automatic step(input logic r, input logic wfs, input logic wv, input logic [15:0] wd,
                       input logic rfs, input logic ren);
      logic        e_en, e_we;
      int          e_addr;
      logic [15:0] e_wd;
      @(negedge clk);
      Reset_i = r; Wr_Frame_Start_i = wfs; Wr_Valid_i = wv; Wr_Data_i = wd;
      Rd_Frame_Start_i = rfs; Rd_En_i = ren;
      #1;
      s_en = Mem_En_o; s_we = Mem_Wr_En_o; s_addr = Mem_Addr_o; s_wd = Mem_Wr_Data_o;
      s_pv = Pixel_Valid_o; s_px = Pixel_o; s_fd = Frame_Done_o; s_ovf = Overflow_o;
      if (s_en && s_we) begin lw_addr = int'(s_addr); lw_data = s_wd; end
      if (s_fd) fd_count++;

      e_en = 0; e_we = 0; e_addr = m_wa; e_wd = 16'h0;
      if (r) e_addr = 0;
      else if (ren) begin e_en = 1; e_addr = rfs ? 0 : m_ra; end
      else if (m_q.size() > 0 && !wfs) begin e_en = 1; e_we = 1; e_wd = m_q[0]; end
      chk("mem_en", 32'(s_en), 32'(e_en));
      chk("mem_wr_en", 32'(s_we), 32'(e_we));
      chk("mem_addr", 32'(s_addr), e_addr);
      if (!(e_en && !e_we)) chk("mem_wr_data", 32'(s_wd), 32'(e_wd));
      chk("pixel_valid", 32'(s_pv), 32'(m_pv));
      chk("pixel", 32'(s_px), 32'(m_px));
      chk("frame_done", 32'(s_fd), 32'(m_fd));
      chk("overflow", 32'(s_ovf), 32'(m_ovf));

      if (r) begin
         model_reset();
      end else begin
         m_pv = m_iss;
         m_px = m_iss ? pat(m_iss_addr) : 16'h0;
         m_iss = ren;
         m_fd = 0;
         if (ren) begin m_iss_addr = e_addr; m_ra = (e_addr + 1) % FP; end
         else if (rfs) m_ra = 0;
         if (e_we) begin
            m_fd = (m_wa == FP - 1);
            void'(m_q.pop_front());
            m_wa = (m_wa + 1) % FP;
         end
         if (!m_run) begin
            if (wfs) begin m_run = 1; m_wa = 0; end
         end else begin
            if (wfs) begin m_q.delete(); m_wa = 0; end
            if (wv) begin
               if (m_q.size() < DEPTH) m_q.push_back(wd);
               else m_ovf = 1;
            end
         end
      end
   endtask

   typedef struct {
      logic        r, wfs, wv;
      logic [15:0] wd;
      logic        rfs, ren;
      logic        e_en, e_we;
      logic [16:0] e_addr;
      logic [15:0] e_wd;
      logic        e_pv;
      logic [15:0] e_px;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic wfs, input logic wv, input logic [15:0] wd,
                               input logic rfs, input logic ren, input logic e_en, input logic e_we,
                               input logic [16:0] e_addr, input logic [15:0] e_wd,
                               input logic e_pv, input logic [15:0] e_px);
      vec_t v;
      v.r = r; v.wfs = wfs; v.wv = wv; v.wd = wd; v.rfs = rfs; v.ren = ren;
      v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd; v.e_pv = e_pv; v.e_px = e_px;
      return v;
   endfunction

   vec_t tbl[13];

   initial begin
      logic ren_burst;
      tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0);
      tbl[1]  = mk(0, 0, 1, 16'hDEAD, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0);
      tbl[2]  = mk(0, 0, 1, 16'hBEEF, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0);
      tbl[3]  = mk(0, 1, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0);
      tbl[4]  = mk(0, 0, 1, 16'h1111, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0);
      tbl[5]  = mk(0, 0, 1, 16'h2222, 0, 0,  1, 1, 0, 16'h1111, 0, 16'h0);
      tbl[6]  = mk(0, 0, 1, 16'h3333, 0, 0,  1, 1, 1, 16'h2222, 0, 16'h0);
      tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 1, 2, 16'h3333, 0, 16'h0);
      tbl[8]  = mk(0, 0, 0, 16'h0000, 0, 0,  0, 0, 3, 16'h0000, 0, 16'h0);
      tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 1,  1, 0, 0, 16'h0000, 0, 16'h0);
      tbl[10] = mk(0, 0, 0, 16'h0000, 0, 0,  0, 0, 3, 16'h0000, 0, 16'h0);
      tbl[11] = mk(0, 0, 0, 16'h0000, 0, 0,  0, 0, 3, 16'h0000, 1, pat(0));
      tbl[12] = mk(0, 0, 0, 16'h0000, 0, 0,  0, 0, 3, 16'h0000, 0, 16'h0);

      Reset_i = 1; Wr_Frame_Start_i = 0; Wr_Valid_i = 0; Wr_Data_i = 0;
      Rd_Frame_Start_i = 0; Rd_En_i = 0; fd_count = 0; lw_addr = -1; lw_data = 0;
      repeat (2) @(posedge clk);
      model_reset();

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].wfs, tbl[i].wv, tbl[i].wd, tbl[i].rfs, tbl[i].ren);
         chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].e_en));
         chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].e_addr));
         if (!(tbl[i].e_en && !tbl[i].e_we))
            chk($sformatf("tbl%0d_wdata", i), 32'(s_wd), 32'(tbl[i].e_wd));
         chk($sformatf("tbl%0d_pvalid", i), 32'(s_pv), 32'(tbl[i].e_pv));
         chk($sformatf("tbl%0d_pixel", i), 32'(s_px), 32'(tbl[i].e_px));
         chk($sformatf("tbl%0d_ovf", i), 32'(s_ovf), 32'h0);
      end

      // Pixels before the first frame start are ignored entirely.
      step(1, 0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 16'(16'h0500 + i), 0, 0);
         chk("wait_sync_no_write", 32'(s_we), 32'h0);
         chk("wait_sync_no_ovf", 32'(s_ovf), 32'h0);
      end
      step(0, 0, 0, 16'h0, 0, 0);
      chk("wait_sync_fifo_empty", 32'(s_en), 32'h0);

      // Reads starve writes; the fifth push overflows and the flag sticks.
      step(1, 0, 0, 16'h0, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 16'(16'h0100 + i), 0, 1);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("ovf_set", 32'(s_ovf), 32'h1);
      chk("ovf_first_drain_addr", 32'(s_addr), 32'h0);
      chk("ovf_first_drain_data", 32'(s_wd), 32'h0100);
      repeat (6) step(0, 0, 0, 16'h0, 0, 0);
      chk("ovf_sticky", 32'(s_ovf), 32'h1);
      chk("ovf_last_drain_addr", 32'(lw_addr), 32'h3);
      chk("ovf_last_drain_data", 32'(lw_data), 32'h0103);

      // Write FP+1 pixels: exactly one frame-done pulse, last pixel wraps to address 0.
      step(1, 0, 0, 16'h0, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      fd_count = 0;
      for (int i = 0; i <= FP; i++) step(0, 0, 1, 16'(16'h2000 + i), 0, 0);
      repeat (3) step(0, 0, 0, 16'h0, 0, 0);
      chk("wrap_frame_done_count", 32'(fd_count), 32'h1);
      chk("wrap_last_addr", 32'(lw_addr), 32'h0);
      chk("wrap_last_data", 32'(lw_data), 32'(16'h2000 + FP));

      // Frame start while reads hold the port drops queued pixels.
      step(1, 0, 0, 16'h0, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 16'(16'h0B01 + i), 0, 1);
      step(0, 1, 1, 16'hAAAA, 0, 1);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("flush_first_we", 32'(s_we), 32'h1);
      chk("flush_first_addr", 32'(s_addr), 32'h0);
      chk("flush_first_data", 32'(s_wd), 32'hAAAA);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("flush_old_gone", 32'(s_en), 32'h0);

      // Read frame start at rd_addr 37, then reset mid-stream.
      step(1, 0, 0, 16'h0, 0, 0);
      step(0, 1, 0, 16'h0, 0, 0);
      for (int i = 0; i < 37; i++) step(0, 0, 1, 16'(i), 0, 1);
      step(0, 0, 1, 16'h0C00, 1, 1);
      chk("rfs_addr0", 32'(s_addr), 32'h0);
      chk("rfs_read", 32'(s_en && !s_we), 32'h1);
      step(0, 0, 1, 16'h0C01, 0, 1);
      chk("rfs_addr1", 32'(s_addr), 32'h1);
      step(1, 0, 1, 16'h0C02, 0, 1);
      chk("reset_no_access", 32'(s_en), 32'h0);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("post_reset_outputs",
          32'({s_en, s_we, s_pv, s_fd, s_ovf}), 32'h0);
      chk("post_reset_addr_data", 32'({s_addr, s_wd}), 32'h0);
      chk("post_reset_pixel", 32'(s_px), 32'h0);
      step(0, 0, 1, 16'h0C03, 0, 0);
      step(0, 0, 0, 16'h0, 0, 0);
      chk("post_reset_wait_sync", 32'(s_en), 32'h0);

      // Randomized traffic against the model.
      step(1, 0, 0, 16'h0, 0, 0);
      ren_burst = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) ren_burst = ~ren_burst;
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) < 7),
              16'($urandom),
              ($urandom_range(0, 79) == 0),
              ren_burst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
Shares one single-port pixel RAM (1-cycle read latency) between the OV7670 capture path (writer) and the VGA controller (reader).
- VGA reads are real-time and always win the port.
- Camera pixels are queued in a small write FIFO and drained into RAM on cycles with no read.
- Owns the write and read address counters, frame wrap, overflow detection and frame-done signalling.

Parameters:
DATA_W, 16, pixel width (RGB565 as packed by capture path)
ADDR_W, 17, RAM address width
FRAME_PIXELS, 76800, pixels per frame (320x240); addresses wrap at FRAME_PIXELS-1
FIFO_DEPTH, 4, write FIFO entries (power of two, >=2)

Ports:
Clk_i  in  1  system clock
Reset_i  in  1  reset; one clock, synchronous, active-high
Wr_Frame_Start_i  in  1  1-cycle pulse, camera frame start
Wr_Valid_i  in  1  camera pixel valid
Wr_Data_i  in  DATA_W  camera pixel
Rd_Frame_Start_i  in  1  1-cycle pulse, VGA frame start
Rd_En_i  in  1  VGA read request, one pixel per cycle
Pixel_o  out  DATA_W  pixel to VGA
Pixel_Valid_o  out  1  Pixel_o valid
Mem_En_o  out  1  RAM enable
Mem_Wr_En_o  out  1  RAM write enable
Mem_Addr_o  out  ADDR_W  RAM address
Mem_Wr_Data_o  out  DATA_W  RAM write data
Mem_Rd_Data_i  in  DATA_W  RAM read data, valid 1 cycle after read issue
Frame_Done_o  out  1  1-cycle pulse, last pixel of a frame written
Overflow_o  out  1  sticky, a camera pixel was dropped

Behaviour:
- Reset (sync, high):
  - All outputs 0.
  - wr_addr=0, rd_addr=0, FIFO empty, state WAIT_SYNC.
  - Reset mid-frame discards queued pixels; no RAM access in the reset cycle.
- Write FSM states: WAIT_SYNC, RUN.
  - WAIT_SYNC -> RUN on Wr_Frame_Start_i.
  - In WAIT_SYNC, Wr_Valid_i is ignored: no push, no overflow.
  - RUN has no exit except reset.
- FIFO push: in RUN, Wr_Valid_i=1 and (not full or pop in the same cycle).
  - Push with FIFO full and no pop: pixel dropped, Overflow_o<=1 and held until reset.
  - Push and pop in the same cycle are allowed.
- Wr_Frame_Start_i in RUN:
  - Flushes the FIFO and sets wr_addr<=0. There is no write to RAM in that cycle.
  - If Wr_Valid_i is high in the same cycle, that pixel is pushed as pixel 0 of the new frame.
- Port arbitration (combinational from registers plus Rd_En_i), per cycle:
  - Rd_En_i=1: Mem_En_o=1, Mem_Wr_En_o=0, Mem_Addr_o=rd_addr; rd_addr increments. Read is served in any state.
  - else FIFO not empty and no Wr_Frame_Start_i: pop head; Mem_En_o=1, Mem_Wr_En_o=1, Mem_Addr_o=wr_addr, Mem_Wr_Data_o=head; wr_addr increments.
  - else Mem_En_o=0, Mem_Wr_En_o=0, Mem_Addr_o=wr_addr, Mem_Wr_Data_o=0.
- Earliest write is the cycle after the push (FIFO is registered; no fall-through).
- Address wrap:
  - Each counter goes FRAME_PIXELS-1 -> 0.
  - The write at FRAME_PIXELS-1 pulses Frame_Done_o for exactly 1 cycle, in the cycle after the write.
- Rd_Frame_Start_i: rd_addr<=0. If Rd_En_i is high in the same cycle, the read uses address 0 and rd_addr<=1.
- Read latency:
  - Rd_En_i high in cycle N -> RAM data in N+1 -> Pixel_o registered, Pixel_Valid_o=1 in N+2.
  - Otherwise Pixel_Valid_o=0 and Pixel_o=0.
  - Back-to-back reads stream 1 pixel/cycle.
- Starvation: writes stall while Rd_En_i is high; they are recovered in blanking. FIFO sizing is the integrator's responsibility, and overflow is the only indication.

Decomposition:
- Shared parameter include (ov7670_parameters) gains:
  - FSM encodings fba_wait_sync_p, fba_run_p
  - default FRAME_PIXELS, ADDR_W and DATA_W constants
- One sub-module: pixel_fifo. It is a synchronous FIFO with push/pop/flush and full/empty flags, parameterised by DATA_W and FIFO_DEPTH.
- Arbiter, address counters and output pipeline stay in frame_buffer_arbiter.

Test Plan:
- After reset, Wr_Valid_i=1 for 10 cycles with no Wr_Frame_Start_i -> Mem_Wr_En_o stays 0, Overflow_o 0.
- Wr_Frame_Start_i, then pixels 0x1111, 0x2222, 0x3333 in cycles N..N+2 with Rd_En_i=0 -> writes to addr 0, 1, 2 in cycles N+1..N+3.
- RUN, pushes every cycle, Rd_En_i=1 for 5 cycles from rd_addr 0 -> reads addr 0..4; Pixel_Valid_o high 2 cycles after each read; 5th push drops and Overflow_o=1 and stays 1; writes resume addr-ordered after Rd_En_i falls.
- FRAME_PIXELS=8, write 9 pixels -> 8th written at addr 7 with Frame_Done_o pulse next cycle; 9th written at addr 0.
- 3 pixels queued, Rd_En_i held high, Wr_Frame_Start_i plus Wr_Valid_i (0xAAAA) -> old pixels never written; first write after Rd_En_i falls is 0xAAAA at addr 0.
- Rd_Frame_Start_i with Rd_En_i at rd_addr 37 -> read addr 0, next read addr 1. Reset asserted mid-stream -> next cycle all outputs 0, FIFO empty, state WAIT_SYNC.
